// File: rtl/w_stage_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : w_stage_unit_if
// Purpose  : M-to-W pipeline handshake and register-file write-port bundle.
// Revision : 1.0 - initial release
// ============================================================================
interface w_stage_unit_if #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
);
    logic              en_W;
    logic              flush_W;
    logic              valid_M;
    logic [31:0]       IR_M;
    logic [31:0]       PC8_M;
    logic [31:0]       AO_M;
    logic [31:0]       DR_M;
    logic [31:0]       HI_M;
    logic [31:0]       LO_M;
    logic              cond_M;
    logic [31:0]       IR_W;
    logic              grf_we;
    logic [REG_AW-1:0] grf_a3;
    logic [31:0]       grf_wd;
    logic [CNT_W-1:0]  retired;

    modport master (
        output en_W, flush_W, valid_M, IR_M, PC8_M, AO_M, DR_M, HI_M, LO_M, cond_M,
        input  IR_W, grf_we, grf_a3, grf_wd, retired
    );

    modport slave (
        input  en_W, flush_W, valid_M, IR_M, PC8_M, AO_M, DR_M, HI_M, LO_M, cond_M,
        output IR_W, grf_we, grf_a3, grf_wd, retired
    );
endinterface
`default_nettype wire

// File: rtl/w_stage_unit.sv
`default_nettype none
// ============================================================================
// Module   : w_stage_unit
// Purpose  : MIPS writeback stage: W register, load extension, GRF write port.
//            Optional macro W_COND_MOVE_EN enables movn/movz writes gated by cond.
// Revision : 1.0 - initial release
// ============================================================================
module w_stage_unit #(
    parameter int REG_AW   = 5,
    parameter int LINK_REG = 31,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    w_stage_unit_if.slave    bus
);
    localparam logic [5:0] c_OP_SPECIAL = 6'h00;
    localparam logic [5:0] c_OP_JAL     = 6'h03;
    localparam logic [5:0] c_OP_ADDI    = 6'h08;
    localparam logic [5:0] c_OP_ADDIU   = 6'h09;
    localparam logic [5:0] c_OP_SLTI    = 6'h0A;
    localparam logic [5:0] c_OP_SLTIU   = 6'h0B;
    localparam logic [5:0] c_OP_ANDI    = 6'h0C;
    localparam logic [5:0] c_OP_ORI     = 6'h0D;
    localparam logic [5:0] c_OP_XORI    = 6'h0E;
    localparam logic [5:0] c_OP_LUI     = 6'h0F;
    localparam logic [5:0] c_OP_LB      = 6'h20;
    localparam logic [5:0] c_OP_LH      = 6'h21;
    localparam logic [5:0] c_OP_LW      = 6'h23;
    localparam logic [5:0] c_OP_LBU     = 6'h24;
    localparam logic [5:0] c_OP_LHU     = 6'h25;

    localparam logic [5:0] c_FN_SLL  = 6'h00;
    localparam logic [5:0] c_FN_SRL  = 6'h02;
    localparam logic [5:0] c_FN_SRA  = 6'h03;
    localparam logic [5:0] c_FN_SLLV = 6'h04;
    localparam logic [5:0] c_FN_SRLV = 6'h06;
    localparam logic [5:0] c_FN_SRAV = 6'h07;
    localparam logic [5:0] c_FN_JALR = 6'h09;
    localparam logic [5:0] c_FN_MOVZ = 6'h0A;
    localparam logic [5:0] c_FN_MOVN = 6'h0B;
    localparam logic [5:0] c_FN_MFHI = 6'h10;
    localparam logic [5:0] c_FN_MFLO = 6'h12;
    localparam logic [5:0] c_FN_ADD  = 6'h20;
    localparam logic [5:0] c_FN_ADDU = 6'h21;
    localparam logic [5:0] c_FN_SUB  = 6'h22;
    localparam logic [5:0] c_FN_SUBU = 6'h23;
    localparam logic [5:0] c_FN_AND  = 6'h24;
    localparam logic [5:0] c_FN_OR   = 6'h25;
    localparam logic [5:0] c_FN_XOR  = 6'h26;
    localparam logic [5:0] c_FN_NOR  = 6'h27;
    localparam logic [5:0] c_FN_SLT  = 6'h2A;
    localparam logic [5:0] c_FN_SLTU = 6'h2B;

    logic [31:0]      r_ir, r_pc8, r_ao, r_dr, r_hi, r_lo;
    logic             r_valid;
    logic [CNT_W-1:0] r_retired;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ir      <= '0;
            r_pc8     <= '0;
            r_ao      <= '0;
            r_dr      <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_valid   <= 1'b0;
            r_retired <= '0;
        end else if (bus.flush_W) begin
            // Only IR and valid matter for a bubble; other fields keep stale data.
            r_ir    <= '0;
            r_valid <= 1'b0;
        end else if (bus.en_W) begin
            r_ir    <= bus.IR_M;
            r_pc8   <= bus.PC8_M;
            r_ao    <= bus.AO_M;
            r_dr    <= bus.DR_M;
            r_hi    <= bus.HI_M;
            r_lo    <= bus.LO_M;
            r_valid <= bus.valid_M;
            if (bus.valid_M && (r_retired != {CNT_W{1'b1}}))
                r_retired <= r_retired + 1'b1;
        end
    end

    logic w_cmov_ok;
    logic w_is_cmov;
`ifdef W_COND_MOVE_EN
    logic r_cond;
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_cond <= 1'b0;
        else if (!bus.flush_W && bus.en_W)
            r_cond <= bus.cond_M;
    end
    assign w_cmov_ok = w_is_cmov & r_cond;
`else
    logic w_unused_cond;
    assign w_unused_cond = bus.cond_M;
    assign w_cmov_ok     = 1'b0;
`endif

    logic [5:0]  w_op, w_funct;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic        w_rd_wr, w_rt_wr, w_jal;
    logic [31:0] w_wd;
    logic [REG_AW-1:0] w_a3;

    assign w_op   = r_ir[31:26];
    assign w_funct = r_ir[5:0];
    assign w_byte = r_dr[{r_ao[1:0], 3'b000} +: 8];
    assign w_half = r_ao[1] ? r_dr[31:16] : r_dr[15:0];

    always_comb begin
        w_rd_wr   = 1'b0;
        w_rt_wr   = 1'b0;
        w_jal     = 1'b0;
        w_is_cmov = 1'b0;
        w_wd      = r_ao;
        case (w_op)
            c_OP_SPECIAL: begin
                case (w_funct)
                    c_FN_SLL, c_FN_SRL, c_FN_SRA, c_FN_SLLV, c_FN_SRLV, c_FN_SRAV,
                    c_FN_ADD, c_FN_ADDU, c_FN_SUB, c_FN_SUBU, c_FN_AND, c_FN_OR,
                    c_FN_XOR, c_FN_NOR, c_FN_SLT, c_FN_SLTU: w_rd_wr = 1'b1;
                    c_FN_JALR: begin w_rd_wr = 1'b1; w_wd = r_pc8; end
                    c_FN_MFHI: begin w_rd_wr = 1'b1; w_wd = r_hi;  end
                    c_FN_MFLO: begin w_rd_wr = 1'b1; w_wd = r_lo;  end
                    c_FN_MOVZ, c_FN_MOVN: w_is_cmov = 1'b1;
                    default: ;
                endcase
            end
            c_OP_JAL: begin w_jal = 1'b1; w_wd = r_pc8; end
            c_OP_ADDI, c_OP_ADDIU, c_OP_SLTI, c_OP_SLTIU,
            c_OP_ANDI, c_OP_ORI, c_OP_XORI, c_OP_LUI: w_rt_wr = 1'b1;
            c_OP_LB:  begin w_rt_wr = 1'b1; w_wd = {{24{w_byte[7]}}, w_byte};  end
            c_OP_LBU: begin w_rt_wr = 1'b1; w_wd = {24'h0, w_byte};            end
            c_OP_LH:  begin w_rt_wr = 1'b1; w_wd = {{16{w_half[15]}}, w_half}; end
            c_OP_LHU: begin w_rt_wr = 1'b1; w_wd = {16'h0, w_half};            end
            c_OP_LW:  begin w_rt_wr = 1'b1; w_wd = r_dr;                       end
            default: ;
        endcase
    end

    // Non-writers drive address 0 so the port idles at a known value.
    always_comb begin
        w_a3 = '0;
        if (w_jal)
            w_a3 = REG_AW'(LINK_REG);
        else if (w_rd_wr || w_is_cmov)
            w_a3 = REG_AW'(r_ir[15:11]);
        else if (w_rt_wr)
            w_a3 = REG_AW'(r_ir[20:16]);
    end

    assign bus.IR_W    = r_ir;
    assign bus.grf_a3  = w_a3;
    assign bus.grf_wd  = w_wd;
    assign bus.grf_we  = r_valid & (w_rd_wr | w_rt_wr | w_jal | w_cmov_ok) & (w_a3 != '0);
    assign bus.retired = r_retired;
endmodule
`default_nettype wire

// File: tb/tb_w_stage_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_w_stage_unit
// Purpose  : Scoreboard bench for w_stage_unit with a mnemonic-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_w_stage_unit;
    localparam int CNT_W = 3;
    localparam int MAXC  = (1 << CNT_W) - 1;
`ifdef W_COND_MOVE_EN
    localparam bit COND_ON = 1'b1;
`else
    localparam bit COND_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    w_stage_unit_if #(.REG_AW(5), .CNT_W(CNT_W)) bus ();
    w_stage_unit #(.REG_AW(5), .LINK_REG(31), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    typedef struct {
        logic [31:0] ir;
        logic        we;
        logic [4:0]  a3;
        logic [31:0] wd;
        int          ret;
        bit          chk_data;
        string       tag;
    } exp_t;

    exp_t sb[$];
    int n_total = 0;
    int n_bad   = 0;

    logic [31:0] m_ir, m_pc8, m_ao, m_dr, m_hi, m_lo;
    logic        m_cond, m_valid;
    int          m_ret;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        n_total++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, want);
        end
    endtask

    // Instruction -> destination class and write-data source.
    function automatic void describe(input logic [31:0] ir, output string dst, output string src);
        logic [5:0] op, fn;
        op = ir[31:26];
        fn = ir[5:0];
        dst = "none";
        src = "ao";
        if (op == 6'h00) begin
            case (fn)
                6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h20, 6'h21,
                6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B: dst = "rd";
                6'h09: begin dst = "rd"; src = "pc8"; end
                6'h10: begin dst = "rd"; src = "hi";  end
                6'h12: begin dst = "rd"; src = "lo";  end
                6'h0A, 6'h0B: dst = "cmov";
                default: ;
            endcase
        end else begin
            case (op)
                6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F: dst = "rt";
                6'h20, 6'h21, 6'h23, 6'h24, 6'h25: begin dst = "rt"; src = "ld"; end
                6'h03: begin dst = "ra"; src = "pc8"; end
                default: ;
            endcase
        end
    endfunction

    function automatic logic [31:0] load_val(input logic [5:0] op, input logic [31:0] ao, input logic [31:0] dr);
        logic [31:0] b, h;
        b = (dr >> (8 * ao[1:0])) & 32'hFF;
        h = (dr >> (16 * ao[1])) & 32'hFFFF;
        case (op)
            6'h20: load_val = (b >= 128) ? b - 32'd256 : b;
            6'h24: load_val = b;
            6'h21: load_val = (h >= 32768) ? h - 32'd65536 : h;
            6'h25: load_val = h;
            default: load_val = dr;
        endcase
    endfunction

    task automatic push_exp(input string tag, input bit rst_state);
        exp_t e;
        string dst, src;
        bit allowed;
        describe(m_ir, dst, src);
        if (dst == "rd" || dst == "cmov") e.a3 = m_ir[15:11];
        else if (dst == "rt")             e.a3 = m_ir[20:16];
        else if (dst == "ra")             e.a3 = 5'd31;
        else                              e.a3 = 5'd0;
        allowed = (dst != "none");
        if (dst == "cmov") allowed = COND_ON && m_cond;
        e.we = m_valid && allowed && (e.a3 != 0);
        if (src == "hi")       e.wd = m_hi;
        else if (src == "lo")  e.wd = m_lo;
        else if (src == "pc8") e.wd = m_pc8;
        else if (src == "ld")  e.wd = load_val(m_ir[31:26], m_ao, m_dr);
        else                   e.wd = m_ao;
        e.ir = m_ir;
        e.ret = m_ret;
        e.chk_data = e.we || rst_state;
        e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic model_reset();
        m_ir = 0; m_pc8 = 0; m_ao = 0; m_dr = 0; m_hi = 0; m_lo = 0;
        m_cond = 0; m_valid = 0; m_ret = 0;
    endtask

    task automatic cyc(input logic en, input logic fl, input logic vm, input logic [31:0] ir,
                       input logic [31:0] pc8, input logic [31:0] ao, input logic [31:0] dr,
                       input logic [31:0] hi, input logic [31:0] lo, input logic cnd, input string tag);
        bus.en_W = en; bus.flush_W = fl; bus.valid_M = vm; bus.IR_M = ir; bus.PC8_M = pc8;
        bus.AO_M = ao; bus.DR_M = dr; bus.HI_M = hi; bus.LO_M = lo; bus.cond_M = cnd;
        @(posedge clk);
        if (fl) begin
            m_ir = 0; m_valid = 0;
        end else if (en) begin
            m_ir = ir; m_pc8 = pc8; m_ao = ao; m_dr = dr; m_hi = hi; m_lo = lo;
            m_cond = cnd; m_valid = vm;
            if (vm && m_ret < MAXC) m_ret++;
        end
        push_exp(tag, 1'b0);
        #1;
    endtask

    function automatic logic [31:0] r_ins(input logic [5:0] fn, input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
        r_ins = {6'h00, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] i_ins(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt, input logic [15:0] imm);
        i_ins = {op, rs, rt, imm};
    endfunction

    // Monitor: W outputs are stable between edges, so sample on the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk({e.tag, " IR_W"}, bus.IR_W, e.ir);
                chk({e.tag, " grf_we"}, {31'b0, bus.grf_we}, {31'b0, e.we});
                chk({e.tag, " retired"}, {29'b0, bus.retired}, e.ret);
                if (e.chk_data) begin
                    chk({e.tag, " grf_a3"}, {27'b0, bus.grf_a3}, {27'b0, e.a3});
                    chk({e.tag, " grf_wd"}, bus.grf_wd, e.wd);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    logic [5:0] rfn [0:13] = '{6'h00, 6'h03, 6'h07, 6'h08, 6'h09, 6'h0A, 6'h0B,
                               6'h10, 6'h11, 6'h12, 6'h18, 6'h21, 6'h27, 6'h2B};
    logic [5:0] iop [0:16] = '{6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h09, 6'h0D, 6'h0F,
                               6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2B, 6'h0A};

    initial begin
        logic [31:0] ir;
        reset = 1'b1;
        bus.en_W = 0; bus.flush_W = 0; bus.valid_M = 0; bus.IR_M = 0; bus.PC8_M = 0;
        bus.AO_M = 0; bus.DR_M = 0; bus.HI_M = 0; bus.LO_M = 0; bus.cond_M = 0;
        model_reset();
        repeat (2) @(posedge clk);
        push_exp("reset", 1'b1);
        #1 reset = 1'b0;

        cyc(1, 0, 0, 32'h0, 0, 0, 0, 0, 0, 0, "idle");
        cyc(1, 0, 1, 32'h0, 0, 32'h1234, 0, 0, 0, 0, "nop");
        chk("nop retired", {29'b0, bus.retired}, 32'd1);

        cyc(1, 0, 1, i_ins(6'h20, 5'd1, 5'd8, 16'h0003), 0, 32'h1003, 32'h80FF_FF7F, 0, 0, 0, "lb");
        chk("lb wd", bus.grf_wd, 32'hFFFF_FF80);
        cyc(1, 0, 1, i_ins(6'h25, 5'd1, 5'd8, 16'h0002), 0, 32'h1002, 32'h80FF_FF7F, 0, 0, 0, "lhu");
        chk("lhu wd", bus.grf_wd, 32'h0000_80FF);

        cyc(1, 0, 1, {6'h03, 26'h00_0C02}, 32'h0000_3008, 32'h77, 0, 0, 0, 0, "jal");
        chk("jal a3", {27'b0, bus.grf_a3}, 32'd31);
        for (int i = 0; i < 3; i++)
            cyc(0, 0, 1, r_ins(6'h21, 5'd2, 5'd3, 5'd9), 32'hDEAD, 32'hBEEF, 1, 2, 3, 1, "stall");

        cyc(1, 1, 1, r_ins(6'h21, 5'd2, 5'd3, 5'd5), 0, 32'h99, 0, 0, 0, 0, "flush");
        chk("flush IR_W", bus.IR_W, 32'h0);

        cyc(1, 0, 1, r_ins(6'h0B, 5'd2, 5'd3, 5'd4), 0, 32'h55, 0, 0, 0, 0, "movn c0");
        chk("movn c0 we", {31'b0, bus.grf_we}, 32'd0);
        cyc(1, 0, 1, r_ins(6'h0B, 5'd2, 5'd3, 5'd4), 0, 32'h55, 0, 0, 0, 1, "movn c1");
        chk("movn c1 we", {31'b0, bus.grf_we}, COND_ON ? 32'd1 : 32'd0);

        // Asynchronous reset between edges must clear the counter at once.
        @(negedge clk);
        #1 reset = 1'b1;
        #1;
        chk("async retired", {29'b0, bus.retired}, 32'd0);
        chk("async we", {31'b0, bus.grf_we}, 32'd0);
        model_reset();
        push_exp("after reset", 1'b1);
        @(posedge clk);
        #1 reset = 1'b0;

        for (int i = 0; i < 9; i++)
            cyc(1, 0, 1, r_ins(6'h21, 5'd1, 5'd2, 5'(i + 1)), 0, 32'(i * 3), 0, 0, 0, 0, "sat");
        chk("retired sat", {29'b0, bus.retired}, 32'd7);

        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 1) == 0)
                ir = r_ins(rfn[$urandom_range(0, 13)], 5'($urandom), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
            else
                ir = i_ins(iop[$urandom_range(0, 16)], 5'($urandom), 5'($urandom_range(0, 7)), 16'($urandom));
            cyc($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0, $urandom_range(0, 4) != 0, ir,
                $urandom, $urandom, $urandom, $urandom, $urandom, 1'($urandom), "rand");
        end

        repeat (3) @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            n_total++;
            n_bad++;
            $display("FAIL drain: got %0d pending want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
